writeback_stage: RTL
====================

Name: writeback_stage

Overview:
Final stage of the pipelined RV32I core and the producer of the write-port signals the decode stage consumes (ResultW, RdW, RegWriteW).
- Holds the MEM/WB pipeline register, with stall and flush.
- Extracts and extends load data per the RV32I load width.
- Selects the result source.
- Counts retired instructions for the hazard/perf logic.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported
CNT_WIDTH, 64, width of the retired-instruction counter

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
EnW  input  1  MEM/WB register enable; 0 = stall and hold
FlushW  input  1  synchronous bubble insert; clears valid
ValidM  input  1  MEM stage holds a real instruction
RegWriteM  input  1  instruction writes rd
ResultSrcM  input  2  00 ALU, 01 load data, 10 PC+4, 11 extended immediate
RdM  input  5  destination register
ALUResultM  input  DATA_WIDTH  ALU result / load byte address
ReadDataM  input  DATA_WIDTH  raw aligned data-memory word
PCPlus4M  input  DATA_WIDTH  link value
ExtImmM  input  DATA_WIDTH  extended immediate (LUI)
AddressingControlM  input  3  load funct3
ResultW  output  DATA_WIDTH  value written to register file / forwarded
RdW  output  5  write address
RegWriteW  output  1  register-file write enable
ValidW  output  1  W stage holds a real instruction
InstRetW  output  CNT_WIDTH  retired-instruction count

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- While rst_n=0, all pipeline registers clear:
  - ValidW=0, RegWriteW=0, RdW=0.
  - ResultW=0, because the registered ResultSrc is 00 and the registered ALUResult is 0.
  - InstRetW=0.
- Register update at each posedge, in this priority: FlushW, then EnW.
  - FlushW=1: valid=0 and regwrite=0. Data fields may take any value and are don't-care.
  - Else EnW=1: all M-stage inputs are captured.
  - Else (EnW=0): all registers hold.
- Latency: exactly one cycle from M inputs to W outputs. ResultW is combinational from the registered fields; it is not registered again.
- RegWriteW = regwrite_q & valid_q & (rd_q != 0). A write to x0 is never asserted.
- ValidW = valid_q.
- Load extraction uses byte offset off = alu_q[1:0] and raw word rd = rdata_q:
  - 000 LB: byte at off, sign-extended.
  - 100 LBU: byte at off, zero-extended.
  - 001 LH: halfword selected by off[1] (off[0] ignored), sign-extended.
  - 101 LHU: as LH, zero-extended.
  - 010 LW and any other code: full word, off ignored.
  - Byte lanes: off=0 is [7:0], 1 is [15:8], 2 is [23:16], 3 is [31:24]. Halfword off[1]=0 is [15:0], 1 is [31:16].
- ResultW mux: 00 alu_q, 01 extracted load, 10 pc4_q, 11 imm_q.
- InstRetW increments by 1 on a posedge when valid_q=1 and the register advances (EnW=1 or FlushW=1).
  - An instruction is therefore counted exactly once, when it leaves W.
  - A stalled instruction is not double-counted.
  - The counter wraps modulo 2^CNT_WIDTH.
- Simultaneous FlushW=1 and EnW=0: flush wins and the held instruction is counted as retired.
- Reset mid-stall or mid-flush: everything clears immediately, independent of clk.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> RegWriteW=0, RdW=0, ResultW=0, InstRetW=0, without a clock edge; after release, outputs remain 0 until the first enabled capture.
- ALU writeback: ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=00, ALUResultM=0x1234 -> next cycle ResultW=0x1234, RdW=5, RegWriteW=1; RdM=0 under the same stimulus -> RegWriteW=0.
- Loads: ReadDataM=0x80FF7F01.
  - LB with ALUResultM=0x101 -> 0x0000007F.
  - LB with ALUResultM=0x103 -> 0xFFFFFF80.
  - LBU with ALUResultM=0x102 -> 0x000000FF.
  - LH with ALUResultM=0x102 -> 0xFFFF80FF.
  - LHU with ALUResultM=0x100 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Mux: ResultSrcM=10 with PCPlus4M=0x44 -> 0x44; ResultSrcM=11 with ExtImmM=0xABCDE000 -> 0xABCDE000.
- Stall/flush: capture an instruction, hold EnW=0 for 3 cycles -> outputs stable, InstRetW unchanged; then FlushW=1 with EnW=0 -> ValidW=0, RegWriteW=0, InstRetW+1.
- Counter: 10 back-to-back valid instructions with EnW=1, then 2 flushed bubbles -> InstRetW=10.

Source files
------------

// File: rtl/writeback_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, load extraction, result mux
// and retired-instruction counter feeding the decode-stage register-file write port.
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EnW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] ReadDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic [DATA_WIDTH-1:0] ExtImmM,
  input  logic [2:0]            AddressingControlM,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic                  ValidW,
  output logic [CNT_WIDTH-1:0]  InstRetW
);

  logic                  valid_q, regwrite_q;
  logic [1:0]            src_q;
  logic [4:0]            rd_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] alu_q, rdata_q, pc4_q, imm_q;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [DATA_WIDTH-1:0] load_d;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  // An instruction leaves W whenever the register advances, including by flush.
  always_comb begin
    instret_d = instret_q;
    if (valid_q && (EnW || FlushW))
      instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= 2'b00;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      instret_q  <= '0;
    end else begin
      instret_q <= instret_d;
      if (FlushW) begin
        valid_q    <= 1'b0;
        regwrite_q <= 1'b0;
      end else if (EnW) begin
        valid_q    <= ValidM;
        regwrite_q <= RegWriteM;
        src_q      <= ResultSrcM;
        rd_q       <= RdM;
        funct3_q   <= AddressingControlM;
        alu_q      <= ALUResultM;
        rdata_q    <= ReadDataM;
        pc4_q      <= PCPlus4M;
        imm_q      <= ExtImmM;
      end
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (alu_q[1:0])
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    load_d = rdata_q;
    case (funct3_q)
      3'b000: load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_d = {24'h000000, byte_sel};
      3'b001: load_d = {{16{half_sel[15]}}, half_sel};
      3'b101: load_d = {16'h0000, half_sel};
      default: load_d = rdata_q;
    endcase
  end

  always_comb begin
    ResultW = alu_q;
    case (src_q)
      2'b00: ResultW = alu_q;
      2'b01: ResultW = load_d;
      2'b10: ResultW = pc4_q;
      default: ResultW = imm_q;
    endcase
  end

  assign RdW       = rd_q;
  assign ValidW    = valid_q;
  assign RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0);
  assign InstRetW  = instret_q;

endmodule
